// File: rtl/cache_set_array.sv
// N-way set-associative line store: registered lookup, hit-or-allocate writes, round-robin victims, dirty eviction, invalidate sweep.
// 1-cycle lookup and eviction latency; full throughput with no backpressure except during the SETS-cycle invalidate (busy_o).
module cache_set_array #(
    parameter int INDEX_BITS = 6,
    parameter int WAYS       = 2,
    parameter int TAG_BITS   = 21,
    parameter int LINE_BITS  = 128,
    localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SETS      = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_valid_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  rd_done_o,
    output logic                  rd_hit_o,
    output logic [WB-1:0]         rd_way_o,
    output logic [LINE_BITS-1:0]  rd_data_o,
    input  logic                  wr_valid_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_data_i,
    input  logic                  wr_dirty_i,
    output logic                  ev_valid_o,
    output logic [INDEX_BITS-1:0] ev_index_o,
    output logic [TAG_BITS-1:0]   ev_tag_o,
    output logic [LINE_BITS-1:0]  ev_data_o,
    input  logic                  inv_req_i,
    output logic                  busy_o,
    output logic                  inv_done_o
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
    logic                    inv_done_q, inv_done_d;
    logic                    sweeping;

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
    logic [SETS-1:0][WB-1:0]   rr_q;
    logic [TAG_BITS-1:0]       tag_q  [SETS][WAYS];
    logic [LINE_BITS-1:0]      data_q [SETS][WAYS];

    logic                    lk_hit;
    logic [WB-1:0]           lk_way;
    logic [LINE_BITS-1:0]    lk_data;

    logic                    wr_en, wr_hit, inv_found, evict;
    logic [WB-1:0]           hit_way, inv_way, vic_way, wr_way, rr_next;

    logic                    rd_done_q, rd_hit_q;
    logic [WB-1:0]           rd_way_q;
    logic [LINE_BITS-1:0]    rd_data_q;
    logic                    ev_valid_q;
    logic [INDEX_BITS-1:0]   ev_index_q;
    logic [TAG_BITS-1:0]     ev_tag_q;
    logic [LINE_BITS-1:0]    ev_data_q;

    assign sweeping = (state_q == SWEEP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inv_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inv_done_q <= inv_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inv_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (inv_req_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INDEX_BITS'(SETS - 1)) begin
                    state_d    = IDLE;
                    inv_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        lk_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rd_index_i][w] && (tag_q[rd_index_i][w] == rd_tag_i)) begin
                lk_hit  = 1'b1;
                lk_way  = WB'(w);
                lk_data = data_q[rd_index_i][w];
            end
        end
    end

    // Victim is the lowest invalid way; the round-robin pointer only matters once the set is full.
    always_comb begin
        wr_hit    = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[wr_index_i][w] && (tag_q[wr_index_i][w] == wr_tag_i) && !wr_hit) begin
                wr_hit  = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_q[wr_index_i][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
        vic_way = inv_found ? inv_way : rr_q[wr_index_i];
        wr_way  = wr_hit ? hit_way : vic_way;
        rr_next = (rr_q[wr_index_i] == WB'(WAYS - 1)) ? '0 : rr_q[wr_index_i] + 1'b1;
        wr_en   = wr_valid_i && !sweeping;
        evict   = wr_en && !wr_hit && valid_q[wr_index_i][vic_way] && dirty_q[wr_index_i][vic_way];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            rr_q    <= '0;
        end else if (sweeping) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            rr_q[cnt_q]    <= '0;
        end else if (wr_en) begin
            valid_q[wr_index_i][wr_way] <= 1'b1;
            dirty_q[wr_index_i][wr_way] <= wr_hit ? (dirty_q[wr_index_i][wr_way] | wr_dirty_i)
                                                  : wr_dirty_i;
            if (!wr_hit && !inv_found) begin
                rr_q[wr_index_i] <= rr_next;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            tag_q[wr_index_i][wr_way]  <= wr_tag_i;
            data_q[wr_index_i][wr_way] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_done_q  <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_way_q   <= '0;
            rd_data_q  <= '0;
            ev_valid_q <= 1'b0;
            ev_index_q <= '0;
            ev_tag_q   <= '0;
            ev_data_q  <= '0;
        end else begin
            rd_done_q  <= rd_valid_i;
            rd_hit_q   <= rd_valid_i && !sweeping && lk_hit;
            rd_way_q   <= (rd_valid_i && !sweeping && lk_hit) ? lk_way : '0;
            rd_data_q  <= (rd_valid_i && !sweeping && lk_hit) ? lk_data : '0;
            ev_valid_q <= evict;
            ev_index_q <= evict ? wr_index_i : '0;
            ev_tag_q   <= evict ? tag_q[wr_index_i][vic_way] : '0;
            ev_data_q  <= evict ? data_q[wr_index_i][vic_way] : '0;
        end
    end

    assign rd_done_o  = rd_done_q;
    assign rd_hit_o   = rd_hit_q;
    assign rd_way_o   = rd_way_q;
    assign rd_data_o  = rd_data_q;
    assign ev_valid_o = ev_valid_q;
    assign ev_index_o = ev_index_q;
    assign ev_tag_o   = ev_tag_q;
    assign ev_data_o  = ev_data_q;
    assign busy_o     = sweeping;
    assign inv_done_o = inv_done_q;

endmodule

// File: tb/tb_cache_set_array.sv
// Bench for cache_set_array: directed steps plus random traffic against a per-set behavioural model.
module tb_cache_set_array;

    localparam int IB   = 6;
    localparam int W    = 2;
    localparam int TB   = 21;
    localparam int LB   = 128;
    localparam int SETS = 1 << IB;
    localparam int WBW  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_valid_i = 1'b0;
    logic [IB-1:0] rd_index_i = '0;
    logic [TB-1:0] rd_tag_i = '0;
    logic          rd_done_o, rd_hit_o;
    logic [WBW-1:0] rd_way_o;
    logic [LB-1:0] rd_data_o;
    logic          wr_valid_i = 1'b0;
    logic [IB-1:0] wr_index_i = '0;
    logic [TB-1:0] wr_tag_i = '0;
    logic [LB-1:0] wr_data_i = '0;
    logic          wr_dirty_i = 1'b0;
    logic          ev_valid_o;
    logic [IB-1:0] ev_index_o;
    logic [TB-1:0] ev_tag_o;
    logic [LB-1:0] ev_data_o;
    logic          inv_req_i = 1'b0;
    logic          busy_o, inv_done_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: contents of each set plus the replacement pointer and sweep countdown.
    bit            mv   [SETS][W];
    bit            md   [SETS][W];
    logic [TB-1:0] mt   [SETS][W];
    logic [LB-1:0] mdat [SETS][W];
    int            mrr  [SETS];
    int            m_rem = 0;

    cache_set_array #(.INDEX_BITS(IB), .WAYS(W), .TAG_BITS(TB), .LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid_i), .rd_index_i(rd_index_i), .rd_tag_i(rd_tag_i),
        .rd_done_o(rd_done_o), .rd_hit_o(rd_hit_o), .rd_way_o(rd_way_o), .rd_data_o(rd_data_o),
        .wr_valid_i(wr_valid_i), .wr_index_i(wr_index_i), .wr_tag_i(wr_tag_i),
        .wr_data_i(wr_data_i), .wr_dirty_i(wr_dirty_i),
        .ev_valid_o(ev_valid_o), .ev_index_o(ev_index_o), .ev_tag_o(ev_tag_o), .ev_data_o(ev_data_o),
        .inv_req_i(inv_req_i), .busy_o(busy_o), .inv_done_o(inv_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < W; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rd_valid_i = 1'b0; wr_valid_i = 1'b0; inv_req_i = 1'b0;
        cycle();
        chk("rst_rd_done", 128'(rd_done_o), 0);
        chk("rst_rd_hit", 128'(rd_hit_o), 0);
        chk("rst_rd_way", 128'(rd_way_o), 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_ev_valid", 128'(ev_valid_o), 0);
        chk("rst_ev_index", 128'(ev_index_o), 0);
        chk("rst_ev_tag", 128'(ev_tag_o), 0);
        chk("rst_ev_data", ev_data_o, 0);
        chk("rst_busy", 128'(busy_o), 0);
        chk("rst_inv_done", 128'(inv_done_o), 0);
        model_clear();
        m_rem = 0;
        rst = 1'b1;
    endtask

    task automatic op(input logic rv, input int ri, input logic [TB-1:0] rt,
                      input logic wv, input int wi, input logic [TB-1:0] wt,
                      input logic [LB-1:0] wd, input logic wdy, input logic inv);
        logic          e_hit, e_ev, e_idone, swp;
        int            e_way, e_evi, hw, vw;
        logic [LB-1:0] e_data, e_evd;
        logic [TB-1:0] e_evt;
        rd_valid_i = rv; rd_index_i = ri[IB-1:0]; rd_tag_i = rt;
        wr_valid_i = wv; wr_index_i = wi[IB-1:0]; wr_tag_i = wt;
        wr_data_i = wd; wr_dirty_i = wdy; inv_req_i = inv;

        swp = (m_rem > 0);
        e_hit = 1'b0; e_way = 0; e_data = '0;
        if (rv && !swp) begin
            for (int w = 0; w < W; w++) begin
                if (mv[ri][w] && mt[ri][w] == rt) begin
                    e_hit = 1'b1; e_way = w; e_data = mdat[ri][w];
                end
            end
        end
        e_ev = 1'b0; e_evi = 0; e_evt = '0; e_evd = '0;
        if (wv && !swp) begin
            hw = -1;
            for (int w = 0; w < W; w++) if (mv[wi][w] && mt[wi][w] == wt) hw = w;
            if (hw >= 0) begin
                mdat[wi][hw] = wd;
                md[wi][hw] = md[wi][hw] | wdy;
            end else begin
                vw = -1;
                for (int w = 0; w < W; w++) if (!mv[wi][w] && vw < 0) vw = w;
                if (vw < 0) begin
                    vw = mrr[wi];
                    mrr[wi] = (mrr[wi] + 1) % W;
                end
                if (mv[wi][vw] && md[wi][vw]) begin
                    e_ev = 1'b1; e_evi = wi; e_evt = mt[wi][vw]; e_evd = mdat[wi][vw];
                end
                mv[wi][vw] = 1'b1; md[wi][vw] = wdy; mt[wi][vw] = wt; mdat[wi][vw] = wd;
            end
        end
        e_idone = 1'b0;
        if (swp) begin
            m_rem--;
            if (m_rem == 0) begin
                model_clear();
                e_idone = 1'b1;
            end
        end else if (inv) begin
            m_rem = SETS;
        end

        cycle();
        chk("rd_done", 128'(rd_done_o), 128'(rv));
        chk("rd_hit", 128'(rd_hit_o), 128'(e_hit));
        chk("rd_way", 128'(rd_way_o), 128'(e_way));
        chk("rd_data", rd_data_o, e_data);
        chk("ev_valid", 128'(ev_valid_o), 128'(e_ev));
        chk("ev_index", 128'(ev_index_o), 128'(e_evi));
        chk("ev_tag", 128'(ev_tag_o), 128'(e_evt));
        chk("ev_data", ev_data_o, e_evd);
        chk("busy", 128'(busy_o), 128'(m_rem > 0));
        chk("inv_done", 128'(inv_done_o), 128'(e_idone));
    endtask

    function automatic logic [LB-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [LB-1:0] aaa;
        int busy_cnt, done_cnt;
        aaa = {32{4'hA}};

        cycle();
        do_reset();

        // Cold miss, then refill and hit
        op(1, 5, 21'h1234, 0, 0, 0, 0, 0, 0);
        chk("cold_miss_const", 128'(rd_hit_o), 0);
        op(0, 0, 0, 1, 5, 21'h1234, aaa, 0, 0);
        op(1, 5, 21'h1234, 0, 0, 0, 0, 0, 0);
        chk("refill_hit_const", 128'(rd_hit_o), 1);
        chk("refill_data_const", rd_data_o, aaa);

        // Set 3: dirty way 0 evicted by round robin, then clean way 1 replaced silently
        op(0, 0, 0, 1, 3, 21'h10, rnd_line(), 0, 0);
        op(0, 0, 0, 1, 3, 21'h20, rnd_line(), 0, 0);
        op(0, 0, 0, 1, 3, 21'h10, rnd_line(), 1, 0);
        op(0, 0, 0, 1, 3, 21'h30, rnd_line(), 0, 0);
        chk("evict_valid_const", 128'(ev_valid_o), 1);
        chk("evict_tag_const", 128'(ev_tag_o), 128'h10);
        chk("evict_index_const", 128'(ev_index_o), 128'd3);
        op(0, 0, 0, 1, 3, 21'h40, rnd_line(), 0, 0);
        chk("clean_replace_const", 128'(ev_valid_o), 0);

        // Same-cycle write and lookup sees old contents
        op(1, 7, 21'h50, 1, 7, 21'h50, rnd_line(), 0, 0);
        chk("read_old_const", 128'(rd_hit_o), 0);
        op(1, 7, 21'h50, 0, 0, 0, 0, 0, 0);
        chk("read_after_write_const", 128'(rd_hit_o), 1);

        // Random traffic on a few sets with a small tag pool to force hits and evictions
        for (int i = 0; i < 500; i++) begin
            op(($urandom % 4) != 0, int'($urandom % 8), 21'($urandom_range(1, 5)),
               ($urandom % 3) != 0, int'($urandom % 8), 21'($urandom_range(1, 5)),
               rnd_line(), 1'($urandom % 2), 0);
        end

        // Invalidate with a simultaneous write, then traffic during the sweep
        for (int s = 10; s < 14; s++) op(0, 0, 0, 1, s, 21'(s + 100), rnd_line(), 1, 0);
        op(0, 0, 0, 1, 14, 21'h77, rnd_line(), 1, 1);
        busy_cnt = busy_o ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            op(1, 10 + (i % 5), 21'(110 + (i % 5)), 1, 20, 21'h99, rnd_line(), 1, (i % 7) == 0);
            if (busy_o) busy_cnt++;
            if (inv_done_o) done_cnt++;
        end
        chk("busy_cycles", 128'(busy_cnt), 64);
        chk("inv_done_pulses", 128'(done_cnt), 1);
        op(1, 14, 21'h77, 0, 0, 0, 0, 0, 0);
        chk("post_inv_miss_const", 128'(rd_hit_o), 0);
        for (int s = 10; s < 14; s++) op(1, s, 21'(s + 100), 0, 0, 0, 0, 0, 0);

        // Advance rr in set 2, then reset in the middle of a sweep
        op(0, 0, 0, 1, 2, 21'h1, rnd_line(), 1, 0);
        op(0, 0, 0, 1, 2, 21'h2, rnd_line(), 1, 0);
        op(0, 0, 0, 1, 2, 21'h3, rnd_line(), 1, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int s = 0; s < 4; s++) op(1, 2, 21'(s), 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 1, 2, 21'h100, rnd_line(), 1, 0);
        op(0, 0, 0, 1, 2, 21'h200, rnd_line(), 1, 0);
        op(0, 0, 0, 1, 2, 21'h300, rnd_line(), 0, 0);
        chk("rr_reset_evict_tag_const", 128'(ev_tag_o), 128'h100);
        op(1, 2, 21'h200, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
